// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: FSM states,
// load/store width codes and the MEM/WB bundle.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic        memToReg;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] readData;
    logic [31:0] aluOut;
  } memwb_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering for loads/stores; sub-word support is
// built only when MEM_SUBWORD_EN is defined.
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  input  logic [31:0] memData,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misaligned
);

`ifdef MEM_SUBWORD_EN
  logic [7:0]  lByte;
  logic [15:0] lHalf;

  always_comb begin
    lByte      = memData[{offset, 3'b000} +: 8];
    lHalf      = offset[1] ? memData[31:16] : memData[15:0];
    byteEn     = 4'b1111;
    laneData   = storeData;
    misaligned = |offset;
    // width lives in func3[1:0]; bit 2 only picks zero-extension
    unique case (func3[1:0])
      F3_SB[1:0]: begin
        byteEn     = 4'b0001 << offset;
        laneData   = {4{storeData[7:0]}};
        misaligned = 1'b0;
      end
      F3_SH[1:0]: begin
        byteEn     = 4'b0011 << offset;
        laneData   = {2{storeData[15:0]}};
        misaligned = offset[0];
      end
      default: begin
      end
    endcase
    unique case (func3)
      F3_LB:   loadData = {{24{lByte[7]}}, lByte};
      F3_LBU:  loadData = {24'h0, lByte};
      F3_LH:   loadData = {{16{lHalf[15]}}, lHalf};
      F3_LHU:  loadData = {16'h0, lHalf};
      default: loadData = memData;
    endcase
  end
`else
  logic unusedFunc3;

  assign unusedFunc3 = ^func3;
  assign byteEn      = 4'b1111;
  assign laneData    = storeData;
  assign loadData    = memData;
  assign misaligned  = |offset;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// M stage: branch resolve, data-memory access with wait states,
// MEM/WB register. Sub-word accesses under MEM_SUBWORD_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memToRegM,
  input  logic        regWriteM,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic        branchM,
  input  logic        alu_zeroM,
  input  logic [2:0]  func3M,
  input  logic [4:0]  write_regM,
  input  logic [31:0] write_dataM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] PC_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        pc_srcM,
  output logic [31:0] branch_targetM,
  output logic        bus_errM,
  output logic        memToRegW,
  output logic        regWriteW,
  output logic [4:0]  write_regW,
  output logic [31:0] read_dataW,
  output logic [31:0] alu_outW
);

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, stateNext;
  logic [7:0]  waitCnt, waitCntNext;
  logic        access, misaligned, done;
  logic [31:0] loadData;
  memwb_t      wb;

  assign access = memReadM | memWriteM;

  load_store_align u_align (
    .func3      (func3M),
    .offset     (alu_outM[1:0]),
    .storeData  (write_dataM),
    .memData    (dmem_rdata),
    .byteEn     (dmem_be),
    .laneData   (dmem_wdata),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    dmem_req    = 1'b0;
    stallM      = 1'b0;
    bus_errM    = 1'b0;
    done        = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (access && misaligned) begin
            bus_errM = 1'b1;
          end else if (access) begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              done = 1'b1;
            end else begin
              stallM      = 1'b1;
              stateNext   = BUSY;
              waitCntNext = 8'd0;
            end
          end
        end
        BUSY: begin
          // the IDLE cycle already counted as the first wait
          if (waitCnt == LAST_WAIT) begin
            bus_errM    = 1'b1;
            stateNext   = IDLE;
            waitCntNext = 8'd0;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              done      = 1'b1;
              stateNext = IDLE;
            end else begin
              stallM      = 1'b1;
              waitCntNext = waitCnt + 8'd1;
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= 8'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb <= '0;
    end else if (stallM) begin
      wb.regWrite <= 1'b0;
      wb.memToReg <= 1'b0;
    end else begin
      wb.memToReg <= memToRegM & ~bus_errM;
      wb.regWrite <= regWriteM & ~bus_errM;
      wb.writeReg <= write_regM;
      wb.aluOut   <= alu_outM;
      if (done && memReadM) wb.readData <= loadData;
    end
  end

  assign dmem_we        = dmem_req & memWriteM;
  assign dmem_addr      = alu_outM;
  assign pc_srcM        = branchM & alu_zeroM;
  assign branch_targetM = PC_M;
  assign memToRegW      = wb.memToReg;
  assign regWriteW      = wb.regWrite;
  assign write_regW     = wb.writeReg;
  assign read_dataW     = wb.readData;
  assign alu_outW       = wb.aluOut;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        memToRegM, regWriteM, memReadM, memWriteM;
  logic        branchM, alu_zeroM;
  logic [2:0]  func3M;
  logic [4:0]  write_regM;
  logic [31:0] write_dataM, alu_outM, PC_M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stallM, pc_srcM, bus_errM;
  logic [31:0] branch_targetM;
  logic        memToRegW, regWriteW;
  logic [4:0]  write_regW;
  logic [31:0] read_dataW, alu_outW;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          stalls;
  logic        seen;
  logic [31:0] lastRead = 32'h0;

  always #5 clock = ~clock;

  mem_access_stage #(.MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset),
    .memToRegM(memToRegM), .regWriteM(regWriteM),
    .memReadM(memReadM), .memWriteM(memWriteM),
    .branchM(branchM), .alu_zeroM(alu_zeroM),
    .func3M(func3M), .write_regM(write_regM),
    .write_dataM(write_dataM), .alu_outM(alu_outM), .PC_M(PC_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stallM(stallM),
    .pc_srcM(pc_srcM), .branch_targetM(branch_targetM),
    .bus_errM(bus_errM), .memToRegW(memToRegW),
    .regWriteW(regWriteW), .write_regW(write_regW),
    .read_dataW(read_dataW), .alu_outW(alu_outW)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdata);
    exp_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic checkW(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rw"},  32'(regWriteW),  32'(e.rw));
    chk({tag, "_m2r"}, 32'(memToRegW),  32'(e.m2r));
    chk({tag, "_rd"},  32'(write_regW), 32'(e.rd));
    chk({tag, "_alu"}, alu_outW,        e.alu);
    chk({tag, "_rdat"}, read_dataW,     e.rdata);
  endtask

  task automatic idle();
    memToRegM = 0; regWriteM = 0; memReadM = 0; memWriteM = 0;
    branchM = 0; alu_zeroM = 0; func3M = 3'b010; write_regM = 0;
    write_dataM = 0; alu_outM = 0; PC_M = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    memReadM = 1; alu_outM = 32'h100;
    cyc(); #3;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stallM), 0);
    chk("rst_err", 32'(bus_errM), 0);
    chk("rst_rw", 32'(regWriteW), 0);
    chk("rst_alu", alu_outW, 0);
    chk("rst_rdat", read_dataW, 0);
    reset = 0; idle();

    cyc();
    alu_outM = 32'h1234; regWriteM = 1; write_regM = 5;
    pushExp(1, 0, 5, 32'h1234, lastRead);
    #3;
    chk("alu_stall", 32'(stallM), 0);
    chk("alu_req", 32'(dmem_req), 0);
    cyc(); idle();
    checkW("alu");

    cyc();
    memReadM = 1; memToRegM = 1; regWriteM = 1; write_regM = 7;
    alu_outM = 32'h100; func3M = 3'b010;
    pushExp(1, 1, 7, 32'h100, 32'hDEADBEEF);
    lastRead = 32'hDEADBEEF;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      if (stallM) stalls++;
      chk("lw_req", 32'(dmem_req), 1);
      chk("lw_addr", dmem_addr, 32'h100);
      cyc();
      chk("lw_bubble", 32'(regWriteW), 0);
    end
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #3;
    chk("lw_stall_done", 32'(stallM), 0);
    chk("lw_stalls", 32'(stalls), 3);
    cyc(); idle();
    checkW("lw");

    cyc();
    memWriteM = 1; alu_outM = 32'h200; write_dataM = 32'h11223344;
    dmem_ready = 1;
    pushExp(0, 0, 0, 32'h200, lastRead);
    #3;
    chk("sw_req", 32'(dmem_req), 1);
    chk("sw_we", 32'(dmem_we), 1);
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h11223344);
    chk("sw_stall", 32'(stallM), 0);
    cyc(); idle();
    checkW("sw");

    cyc();
    memReadM = 1; regWriteM = 1; write_regM = 9; alu_outM = 32'h300;
    pushExp(0, 0, 9, 32'h300, lastRead);
    stalls = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (bus_errM) begin
        seen = 1;
        chk("abort_req", 32'(dmem_req), 0);
        chk("abort_stall", 32'(stallM), 0);
        break;
      end
      if (stallM) stalls++;
      cyc();
    end
    chk("abort_seen", 32'(seen), 1);
    chk("abort_stalls", 32'(stalls), 15);
    cyc(); idle();
    checkW("abort");
    #3;
    chk("abort_pulse", 32'(bus_errM), 0);
    chk("abort_idle", 32'(stallM), 0);

    cyc();
    memWriteM = 1; alu_outM = 32'h101; write_dataM = 32'h55;
    dmem_ready = 1;
    pushExp(0, 0, 0, 32'h101, lastRead);
    #3;
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_err", 32'(bus_errM), 1);
    chk("mis_stall", 32'(stallM), 0);
    cyc(); idle();
    checkW("mis");
    #3;
    chk("mis_pulse", 32'(bus_errM), 0);

    cyc();
    branchM = 1; alu_zeroM = 1; PC_M = 32'h40;
    #3;
    chk("br_src", 32'(pc_srcM), 1);
    chk("br_tgt", branch_targetM, 32'h40);
    chk("br_req", 32'(dmem_req), 0);
    alu_zeroM = 0;
    #1;
    chk("br_nt", 32'(pc_srcM), 0);

`ifdef MEM_SUBWORD_EN
    cyc(); idle();
    memReadM = 1; memToRegM = 1; regWriteM = 1; write_regM = 3;
    func3M = 3'b000; alu_outM = 32'h103;
    dmem_ready = 1; dmem_rdata = 32'h80FFFFFF;
    pushExp(1, 1, 3, 32'h103, 32'hFFFFFF80);
    #3;
    chk("lb_be", 32'(dmem_be), 32'h8);
    chk("lb_stall", 32'(stallM), 0);
    cyc();
    checkW("lb");
    func3M = 3'b100;
    pushExp(1, 1, 3, 32'h103, 32'h00000080);
    lastRead = 32'h00000080;
    cyc(); idle();
    checkW("lbu");

    cyc();
    memWriteM = 1; func3M = 3'b001; alu_outM = 32'h102;
    write_dataM = 32'h0000ABCD; dmem_ready = 1;
    pushExp(0, 0, 0, 32'h102, lastRead);
    #3;
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_err", 32'(bus_errM), 0);
    cyc(); idle();
    checkW("sh");
`else
    cyc(); idle();
    memWriteM = 1; func3M = 3'b000; alu_outM = 32'h204;
    write_dataM = 32'h000000AB; dmem_ready = 1;
    pushExp(0, 0, 0, 32'h204, lastRead);
    #3;
    chk("sb_be", 32'(dmem_be), 32'hF);
    chk("sb_wdata", dmem_wdata, 32'h000000AB);
    cyc(); idle();
    checkW("sb");
`endif

    cyc();
    memReadM = 1; memToRegM = 1; regWriteM = 1; write_regM = 12;
    alu_outM = 32'h400;
    #3;
    chk("rb_stall0", 32'(stallM), 1);
    cyc();
    reset = 1;
    #3;
    chk("rb_req", 32'(dmem_req), 0);
    chk("rb_stall", 32'(stallM), 0);
    cyc();
    reset = 0; idle();
    chk("rb_rw", 32'(regWriteW), 0);
    chk("rb_m2r", 32'(memToRegW), 0);
    chk("rb_rd", 32'(write_regW), 0);
    chk("rb_alu", alu_outW, 0);
    chk("rb_rdat", read_dataW, 0);
    lastRead = 32'h0;

    cyc();
    alu_outM = 32'h55; regWriteM = 1; write_regM = 1;
    pushExp(1, 0, 1, 32'h55, lastRead);
    #3;
    chk("post_stall", 32'(stallM), 0);
    cyc(); idle();
    checkW("post");
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
